klotski_block_mover: RTL
========================

Name: klotski_block_mover

Overview:
Motor-side responder to the top-level controller's block-move handshake. It accepts one move command per o_bm_en-style pulse: a source cell, a direction and a distance. It then drives the X/Y gantry stepper pulses and the electromagnet to slide the piece, and returns a single-cycle done pulse. The block sits between the top controller and the stepper driver pins, and tracks the gantry head position in board cells (4x4 grid).

Parameters:
STEP_DIV, 50000, clock cycles per step pulse period (minimum 2)
STEPS_PER_CELL, 200, step pulses per one board cell of travel
SETTLE_CYCLES, 5000000, wait after magnet on and after magnet off (minimum 1)

Ports:
i_Clk  in  1  system clock
i_rst_n  in  1  synchronous active-low reset
i_bm_en  in  1  single-cycle move request; sampled only in S_IDLE
i_src_row  in  2  row of the cell to grab (0..3)
i_src_col  in  2  column of the cell to grab (0..3)
i_dir  in  2  push direction: 0 up (row-1), 1 down (row+1), 2 left (col-1), 3 right (col+1)
i_dist  in  2  cells to push (0..3)
o_bm_done  out  1  single-cycle pulse when the move finishes or is rejected
o_err  out  1  single-cycle pulse, coincident with o_bm_done, when the command was rejected
o_busy  out  1  high in every state except S_IDLE
o_x_step  out  1  X stepper pulse, high for one cycle
o_x_dir  out  1  1 = increasing column
o_y_step  out  1  Y stepper pulse, high for one cycle
o_y_dir  out  1  1 = increasing row
o_magnet  out  1  electromagnet enable
o_state  out  3  current state encoding, for debug/LEDs

Behaviour:
- Reset (i_rst_n low at a clock edge):
  - State goes to S_IDLE; all outputs 0; head position (row, col) = (0,0); all counters 0.
  - Reset during any operation drops o_magnet on the next edge. There is no done pulse.
- States: S_IDLE, S_CHECK, S_TRAVEL_X, S_TRAVEL_Y, S_MAG_ON, S_PUSH, S_MAG_OFF, S_DONE.
- S_IDLE: on i_bm_en, latch src/dir/dist and go to S_CHECK. Input changes after latch have no effect.
- S_CHECK (1 cycle): compute target = src + dist along dir, using 3-bit signed arithmetic.
  - Target outside 0..3: go to S_DONE with the err flag set; no motion, magnet stays off.
  - Otherwise go to S_TRAVEL_X.
- S_TRAVEL_X: move the head from its current column to src_col.
  - Take |delta| x STEPS_PER_CELL steps; o_x_dir is set for the whole phase.
  - Zero delta: 1 cycle, then go straight to S_TRAVEL_Y.
  - On exit, head col = src_col.
- S_TRAVEL_Y: same as S_TRAVEL_X, but for rows, using o_y_step/o_y_dir.
- S_MAG_ON:
  - dist = 0: skip to S_DONE with no magnet action.
  - Otherwise assert o_magnet and wait SETTLE_CYCLES, then go to S_PUSH.
- S_PUSH:
  - Magnet stays on.
  - Take dist x STEPS_PER_CELL steps on the axis and polarity given by dir.
  - On exit, head position = target.
- S_MAG_OFF: deassert o_magnet, wait SETTLE_CYCLES, then go to S_DONE.
- S_DONE (1 cycle): o_bm_done=1 (o_err=1 if rejected), then S_IDLE.
- Step timing:
  - A divider counts 0..STEP_DIV-1 in motion phases.
  - A step pulse fires when the divider reaches STEP_DIV-1.
  - A phase of N steps lasts exactly N*STEP_DIV cycles.
  - The dir output is valid from the first cycle of the phase, i.e. at least STEP_DIV-1 cycles before the first pulse.
  - Divider and step counter clear on phase entry.
- Timing guarantees:
  - Step outputs are 0 outside motion phases.
  - o_x_step and o_y_step are never high in the same cycle.
  - o_bm_en is ignored while o_busy = 1.
- Accepted move latency, from the bm_en edge to the done pulse:
  - 1 (CHECK)
  - + max(1, dx·SPC·DIV) + max(1, dy·SPC·DIV) for the two travel phases
  - + SETTLE + dist·SPC·DIV + SETTLE
  - + 1 (DONE)
  - For dist=0 the three magnet/push terms are replaced by 1 cycle (MAG_ON skip).

Decomposition:
- Package klotski_pkg holds:
  - the mover state enum (3-bit);
  - the dir constants DIR_UP/DOWN/LEFT/RIGHT;
  - the BOARD_DIM = 4 constant.
- Sub-module step_pulse_gen: divider plus step counter.
  - Inputs: start, n_steps, dir.
  - Outputs: step, dir_out, done.
  - Instantiated once and muxed onto the X or Y pins by the phase.

Test Plan:
All scenarios use STEP_DIV=4, STEPS_PER_CELL=3, SETTLE_CYCLES=5.
1. Reset, then idle 20 cycles -> all outputs 0, o_state=S_IDLE, no step pulses.
2. From (0,0): bm_en with src(1,2), dir=3, dist=1 ->
   - 6 x pulses with x_dir=1, then 3 y pulses with y_dir=1;
   - magnet high 5 cycles before the first push pulse;
   - 3 x pulses with x_dir=1; magnet low; done 6 cycles after magnet falls;
   - total latency 1+24+12+5+12+5+1 = 60 cycles; head ends at (1,3).
3. Head at (1,3): src(0,3), dir=3, dist=1 -> o_bm_done and o_err high together 2 cycles after bm_en; zero step pulses; magnet never high.
4. Pulse bm_en again mid-S_PUSH of scenario 2 -> ignored; exactly one done pulse; step counts unchanged.
5. Assert reset during S_PUSH -> o_magnet and o_busy are 0 after the next edge; no done pulse; the next move starts from (0,0).
6. dist=0 with src(2,0) from (0,0) -> 6 y pulses only; magnet never high; done at 1+1+24+1+1 = 28 cycles.

Source files
------------

// File: rtl/klotski_pkg.sv
// Shared types and constants for the klotski gantry block mover.
package klotski_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_CHECK    = 3'd1,
        S_TRAVEL_X = 3'd2,
        S_TRAVEL_Y = 3'd3,
        S_MAG_ON   = 3'd4,
        S_PUSH     = 3'd5,
        S_MAG_OFF  = 3'd6,
        S_DONE     = 3'd7
    } mover_state_e;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    localparam int unsigned BOARD_DIM = 4;

    function automatic logic on_board(input logic signed [2:0] pos);
        return (pos >= 3'sd0) && (int'(pos) < int'(BOARD_DIM));
    endfunction

    function automatic logic [1:0] abs_diff(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/step_pulse_gen.sv
// Step pulse generator: emits n_steps one-cycle pulses, one every STEP_DIV cycles,
// the first pulse STEP_DIV-1 cycles after the start edge.
module step_pulse_gen
    import klotski_pkg::*;
#(
    parameter int unsigned STEP_DIV = 50000,
    parameter int unsigned STEP_W   = 10
) (
    input  logic              i_Clk,
    input  logic              i_rst_n,
    input  logic              start,
    input  logic [STEP_W-1:0] n_steps,
    input  logic              dir,
    output logic              step,
    output logic              dir_out,
    output logic              done
);

    localparam int unsigned      DIV_W    = $clog2(STEP_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_DIV - 1);

    logic [DIV_W-1:0]  div_q, div_d;
    logic [STEP_W-1:0] cnt_q, cnt_d;
    logic [STEP_W-1:0] n_q, n_d;
    logic              dir_q, dir_d;
    logic              active_q, active_d;

    assign step    = active_q && (div_q == DIV_LAST);
    assign done    = step && ((cnt_q + STEP_W'(1)) == n_q);
    assign dir_out = active_q && dir_q;

    always_comb begin
        div_d    = div_q;
        cnt_d    = cnt_q;
        n_d      = n_q;
        dir_d    = dir_q;
        active_d = active_q;
        // A new start wins over the final pulse of the previous phase, so
        // back-to-back phases need no idle cycle between them.
        if (start) begin
            active_d = 1'b1;
            div_d    = '0;
            cnt_d    = '0;
            n_d      = n_steps;
            dir_d    = dir;
        end else if (active_q) begin
            if (div_q == DIV_LAST) begin
                div_d = '0;
                cnt_d = cnt_q + STEP_W'(1);
                if (done) begin
                    active_d = 1'b0;
                end
            end else begin
                div_d = div_q + DIV_W'(1);
            end
        end
    end

    always_ff @(posedge i_Clk) begin
        if (!i_rst_n) begin
            div_q    <= '0;
            cnt_q    <= '0;
            n_q      <= '0;
            dir_q    <= 1'b0;
            active_q <= 1'b0;
        end else begin
            div_q    <= div_d;
            cnt_q    <= cnt_d;
            n_q      <= n_d;
            dir_q    <= dir_d;
            active_q <= active_d;
        end
    end

endmodule

// File: rtl/klotski_block_mover.sv
// Gantry block mover: travels to a source cell, grabs the piece with the magnet,
// pushes it dist cells along dir and reports done (or err for off-board targets).
module klotski_block_mover
    import klotski_pkg::*;
#(
    parameter int unsigned STEP_DIV       = 50000,
    parameter int unsigned STEPS_PER_CELL = 200,
    parameter int unsigned SETTLE_CYCLES  = 5000000
) (
    input  logic       i_Clk,
    input  logic       i_rst_n,
    input  logic       i_bm_en,
    input  logic [1:0] i_src_row,
    input  logic [1:0] i_src_col,
    input  logic [1:0] i_dir,
    input  logic [1:0] i_dist,
    output logic       o_bm_done,
    output logic       o_err,
    output logic       o_busy,
    output logic       o_x_step,
    output logic       o_x_dir,
    output logic       o_y_step,
    output logic       o_y_dir,
    output logic       o_magnet,
    output logic [2:0] o_state
);

    localparam int unsigned      STEP_W      = $clog2(3 * STEPS_PER_CELL + 1);
    localparam int unsigned      SET_W       = $clog2(SETTLE_CYCLES + 1);
    localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);

    function automatic logic [STEP_W-1:0] cells_to_steps(input logic [1:0] cells);
        return STEP_W'(cells) * STEP_W'(STEPS_PER_CELL);
    endfunction

    mover_state_e     state_q, state_d;
    logic [1:0]       src_row_q, src_row_d;
    logic [1:0]       src_col_q, src_col_d;
    logic [1:0]       dir_q, dir_d;
    logic [1:0]       dist_q, dist_d;
    logic [1:0]       row_q, row_d;
    logic [1:0]       col_q, col_d;
    logic [SET_W-1:0] settle_q, settle_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             busy_q, busy_d;
    logic             magnet_q, magnet_d;

    logic              gen_start;
    logic [STEP_W-1:0] gen_n;
    logic              gen_dir;
    logic              gen_step;
    logic              gen_dir_out;
    logic              gen_done;

    logic signed [2:0] src_row_s, src_col_s, dist_s;
    logic signed [2:0] tgt_row_s, tgt_col_s;
    logic              tgt_ok;
    logic              x_phase, y_phase;

    step_pulse_gen #(
        .STEP_DIV (STEP_DIV),
        .STEP_W   (STEP_W)
    ) u_step_gen (
        .i_Clk   (i_Clk),
        .i_rst_n (i_rst_n),
        .start   (gen_start),
        .n_steps (gen_n),
        .dir     (gen_dir),
        .step    (gen_step),
        .dir_out (gen_dir_out),
        .done    (gen_done)
    );

    // Target is recomputed from the latched command; it stays stable for the whole move.
    assign src_row_s = signed'({1'b0, src_row_q});
    assign src_col_s = signed'({1'b0, src_col_q});
    assign dist_s    = signed'({1'b0, dist_q});

    always_comb begin
        tgt_row_s = src_row_s;
        tgt_col_s = src_col_s;
        case (dir_q)
            DIR_UP:   tgt_row_s = src_row_s - dist_s;
            DIR_DOWN: tgt_row_s = src_row_s + dist_s;
            DIR_LEFT: tgt_col_s = src_col_s - dist_s;
            default:  tgt_col_s = src_col_s + dist_s;
        endcase
    end

    assign tgt_ok = on_board(tgt_row_s) && on_board(tgt_col_s);

    always_comb begin
        state_d   = state_q;
        src_row_d = src_row_q;
        src_col_d = src_col_q;
        dir_d     = dir_q;
        dist_d    = dist_q;
        row_d     = row_q;
        col_d     = col_q;
        settle_d  = settle_q;
        magnet_d  = magnet_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        gen_start = 1'b0;
        gen_n     = '0;
        gen_dir   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (i_bm_en) begin
                    src_row_d = i_src_row;
                    src_col_d = i_src_col;
                    dir_d     = i_dir;
                    dist_d    = i_dist;
                    state_d   = S_CHECK;
                end
            end
            S_CHECK: begin
                if (!tgt_ok) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end else begin
                    state_d = S_TRAVEL_X;
                    if (src_col_q != col_q) begin
                        gen_start = 1'b1;
                        gen_n     = cells_to_steps(abs_diff(src_col_q, col_q));
                        gen_dir   = src_col_q > col_q;
                    end
                end
            end
            S_TRAVEL_X: begin
                if ((src_col_q == col_q) || gen_done) begin
                    col_d   = src_col_q;
                    state_d = S_TRAVEL_Y;
                    if (src_row_q != row_q) begin
                        gen_start = 1'b1;
                        gen_n     = cells_to_steps(abs_diff(src_row_q, row_q));
                        gen_dir   = src_row_q > row_q;
                    end
                end
            end
            S_TRAVEL_Y: begin
                if ((src_row_q == row_q) || gen_done) begin
                    row_d    = src_row_q;
                    state_d  = S_MAG_ON;
                    settle_d = '0;
                    magnet_d = (dist_q != 2'd0);
                end
            end
            S_MAG_ON: begin
                if (dist_q == 2'd0) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else if (settle_q == SETTLE_LAST) begin
                    state_d   = S_PUSH;
                    gen_start = 1'b1;
                    gen_n     = cells_to_steps(dist_q);
                    gen_dir   = dir_q[0];
                end else begin
                    settle_d = settle_q + SET_W'(1);
                end
            end
            S_PUSH: begin
                if (gen_done) begin
                    row_d    = tgt_row_s[1:0];
                    col_d    = tgt_col_s[1:0];
                    magnet_d = 1'b0;
                    settle_d = '0;
                    state_d  = S_MAG_OFF;
                end
            end
            S_MAG_OFF: begin
                if (settle_q == SETTLE_LAST) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    settle_d = settle_q + SET_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge i_Clk) begin
        if (!i_rst_n) begin
            state_q   <= S_IDLE;
            src_row_q <= '0;
            src_col_q <= '0;
            dir_q     <= '0;
            dist_q    <= '0;
            row_q     <= '0;
            col_q     <= '0;
            settle_q  <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            magnet_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            src_row_q <= src_row_d;
            src_col_q <= src_col_d;
            dir_q     <= dir_d;
            dist_q    <= dist_d;
            row_q     <= row_d;
            col_q     <= col_d;
            settle_q  <= settle_d;
            done_q    <= done_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
            magnet_q  <= magnet_d;
        end
    end

    // One shared generator; the phase decides which axis sees its pulses.
    assign x_phase = (state_q == S_TRAVEL_X) || ((state_q == S_PUSH) && dir_q[1]);
    assign y_phase = (state_q == S_TRAVEL_Y) || ((state_q == S_PUSH) && !dir_q[1]);

    assign o_x_step  = x_phase && gen_step;
    assign o_x_dir   = x_phase && gen_dir_out;
    assign o_y_step  = y_phase && gen_step;
    assign o_y_dir   = y_phase && gen_dir_out;
    assign o_magnet  = magnet_q;
    assign o_bm_done = done_q;
    assign o_err     = err_q;
    assign o_busy    = busy_q;
    assign o_state   = state_q;

endmodule
